// File: rtl/sha3_buf_arbiter_if.sv
// Request/grant and buffer-strobe bundle between the lbuf/sbuf/sha3 requesters
// and the shared Keccak lane buffer arbiter.
interface sha3_buf_arbiter_if #(
  parameter int OFF_W = 5
);
  logic             lbuf_req;
  logic [OFF_W-1:0] lbuf_len;
  logic             sbuf_req;
  logic [OFF_W-1:0] sbuf_len;
  logic             sha3_req;
  logic [2:0]       grant;
  logic             rd_en;
  logic [OFF_W-1:0] rd_off;
  logic             wr_en;
  logic [OFF_W-1:0] wr_off;
  logic             busy;
  logic             done;
  logic [1:0]       done_id;

  modport master (
    output lbuf_req, lbuf_len, sbuf_req, sbuf_len, sha3_req,
    input  grant, rd_en, rd_off, wr_en, wr_off, busy, done, done_id
  );

  modport slave (
    input  lbuf_req, lbuf_len, sbuf_req, sbuf_len, sha3_req,
    output grant, rd_en, rd_off, wr_en, wr_off, busy, done, done_id
  );
endinterface

// File: rtl/sha3_buf_arbiter.sv
// Arbitrates the shared Keccak lane buffer between lbuf, sbuf and the sha3 ALU,
// sequencing read/write offsets for one transfer at a time.
module sha3_buf_arbiter #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 25,
  parameter int OFF_W  = 5
) (
  input logic                CLK,
  input logic                RST,
  sha3_buf_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [OFF_W-1:0] DEPTH_L = OFF_W'(DEPTH);
  localparam logic [OFF_W-1:0] ZERO_L  = {OFF_W{1'b0}};
  localparam logic [OFF_W-1:0] ONE_L   = {{(OFF_W-1){1'b0}}, 1'b1};

  function automatic logic [OFF_W-1:0] eff_len(input logic [OFF_W-1:0] len);
    if (len == ZERO_L || len > DEPTH_L) begin
      return DEPTH_L;
    end else begin
      return len;
    end
  endfunction

  function automatic logic [1:0] owner_id(input logic [2:0] g);
    case (g)
      3'b001:  return 2'd0;
      3'b010:  return 2'd1;
      3'b100:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  state_t           state_r, state_nx;
  logic [2:0]       grant_r, grant_nx;
  logic [OFF_W-1:0] len_r, len_nx;
  logic             rd_en_r, rd_en_nx;
  logic [OFF_W-1:0] rd_off_r, rd_off_nx;
  logic             wr_en_r;
  logic [OFF_W-1:0] wr_off_r;
  logic             busy_r, busy_nx;
  logic             done_r, done_nx;
  logic [1:0]       done_id_r, done_id_nx;
  logic             starve_r, starve_nx;
  logic             sha3_win_s, req_any_s;

  // sha3 yields to a pending buffer request right after its own transfer
  assign sha3_win_s = bus.sha3_req && !(starve_r && (bus.lbuf_req || bus.sbuf_req));
  assign req_any_s  = bus.sha3_req || bus.lbuf_req || bus.sbuf_req;

  // Next-state and next-output decode
  always_comb begin
    state_nx   = state_r;
    grant_nx   = grant_r;
    len_nx     = len_r;
    rd_en_nx   = 1'b0;
    rd_off_nx  = rd_off_r;
    done_nx    = 1'b0;
    done_id_nx = 2'd0;
    starve_nx  = starve_r;
    case (state_r)
      IDLE: begin
        if (sha3_win_s) begin
          grant_nx = 3'b001;
          len_nx   = DEPTH_L;
        end else if (bus.lbuf_req) begin
          grant_nx  = 3'b010;
          len_nx    = eff_len(bus.lbuf_len);
          starve_nx = 1'b0;
        end else if (bus.sbuf_req) begin
          grant_nx  = 3'b100;
          len_nx    = eff_len(bus.sbuf_len);
          starve_nx = 1'b0;
        end else begin
          grant_nx = 3'b000;
        end
        if (req_any_s) begin
          state_nx  = XFER;
          rd_en_nx  = 1'b1;
          rd_off_nx = ZERO_L;
        end else begin
          state_nx = IDLE;
        end
      end
      XFER: begin
        if (rd_off_r == len_r - ONE_L) begin
          state_nx   = DRAIN;
          done_nx    = 1'b1;
          done_id_nx = owner_id(grant_r);
        end else begin
          rd_en_nx  = 1'b1;
          rd_off_nx = rd_off_r + ONE_L;
        end
      end
      DRAIN: begin
        state_nx  = IDLE;
        grant_nx  = 3'b000;
        rd_off_nx = ZERO_L;
        starve_nx = grant_r[0];
      end
      default: begin
        state_nx  = IDLE;
        grant_nx  = 3'b000;
        rd_off_nx = ZERO_L;
      end
    endcase
    busy_nx = (state_nx != IDLE);
  end

  // State and registered outputs; the write side trails the read side by one cycle
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r   <= IDLE;
      grant_r   <= 3'b000;
      len_r     <= ZERO_L;
      rd_en_r   <= 1'b0;
      rd_off_r  <= ZERO_L;
      wr_en_r   <= 1'b0;
      wr_off_r  <= ZERO_L;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      done_id_r <= 2'd0;
      starve_r  <= 1'b0;
    end else begin
      state_r   <= state_nx;
      grant_r   <= grant_nx;
      len_r     <= len_nx;
      rd_en_r   <= rd_en_nx;
      rd_off_r  <= rd_off_nx;
      wr_en_r   <= rd_en_r;
      wr_off_r  <= rd_off_r;
      busy_r    <= busy_nx;
      done_r    <= done_nx;
      done_id_r <= done_id_nx;
      starve_r  <= starve_nx;
    end
  end

  assign bus.grant   = grant_r;
  assign bus.rd_en   = rd_en_r;
  assign bus.rd_off  = rd_off_r;
  assign bus.wr_en   = wr_en_r;
  assign bus.wr_off  = wr_off_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.done_id = done_id_r;

endmodule

// File: doc/sha3_buf_arbiter.md
SHA3_BUF_ARBITER -- requirements
Module: sha3_buf_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 64, buffer/dmem word width (informational; no data passes through this block).
REQ-002 SHALL have parameter DEPTH, default 25, Keccak lanes held in the shared buffer.
REQ-003 SHALL have parameter OFF_W, default 5, offset width, ceil(log2(DEPTH)).
REQ-004 CLK  input  1  clock; all state changes on the rising edge.
REQ-005 RST  input  1  reset, synchronous, active-low.
REQ-006 lbuf_req  input  1  level request from lbuf, dmem -> buffer.
REQ-007 lbuf_len  input  OFF_W  lbuf word count.
REQ-008 sbuf_req  input  1  level request from sbuf, buffer -> dmem.
REQ-009 sbuf_len  input  OFF_W  sbuf word count.
REQ-010 sha3_req  input  1  level request from the sha3 ALU, state -> buffer; length is always DEPTH.
REQ-011 grant  output  3  one-hot owner {sbuf,lbuf,sha3}; all zero when idle.
REQ-012 rd_en  output  1  read strobe to the current source (dmem, buffer or sha3 state).
REQ-013 rd_off  output  OFF_W  source offset.
REQ-014 wr_en  output  1  write strobe to the current destination.
REQ-015 wr_off  output  OFF_W  destination offset; always rd_off of the previous cycle.
REQ-016 busy  output  1  high whenever state is not IDLE; drives the pipeline stall.
REQ-017 done  output  1  one-cycle pulse marking the last write of a transfer.
REQ-018 done_id  output  2  owner of the completing transfer: 0=sha3, 1=lbuf, 2=sbuf; valid only with done.

Function
REQ-019 The FSM SHALL have three states, IDLE, XFER and DRAIN, encoded in 2 bits.
REQ-020 In IDLE, requests SHALL be sampled every cycle; if any is high, the winner is latched into grant, its length into len_q, rd_off is cleared to 0, and the FSM enters XFER on the next edge.
REQ-021 Priority SHALL be sha3 > lbuf > sbuf, except that sha3 loses to any pending lbuf/sbuf request when the previous completed transfer was also sha3 (anti-starvation flag, cleared by any non-sha3 grant).
REQ-022 In XFER, rd_en SHALL be 1 every cycle and rd_off SHALL increment by 1 per cycle, covering 0 .. len_q-1.
REQ-023 The FSM SHALL leave XFER for DRAIN on the cycle rd_off == len_q-1.
REQ-024 wr_en SHALL equal rd_en delayed one cycle and wr_off SHALL equal rd_off delayed one cycle; this models 1-cycle synchronous source read latency.
REQ-025 In DRAIN: rd_en=0, wr_en=1 (last word), done=1, done_id=owner; the next state is IDLE, where grant clears.
REQ-026 A length of 0 or greater than DEPTH SHALL be treated as DEPTH.
REQ-027 A transfer of length L SHALL hold busy for exactly L+1 cycles.
REQ-028 Earliest first write SHALL occur 2 cycles after the IDLE cycle that samples the request.
REQ-029 Requests SHALL be ignored outside IDLE; a request dropped mid-transfer does not abort it; losing requests stay pending (level) and are served in later IDLE cycles.
REQ-030 A requester SHALL deassert its request in the done cycle; a request still high in the following IDLE cycle is treated as a new transfer.
REQ-031 Length inputs SHALL be sampled only at grant; later changes have no effect.
REQ-032 Exactly one grant bit SHALL be set while busy; at most one of wr_en/done per owner per cycle.

Reset
REQ-033 RST=0 at a clock edge SHALL force state IDLE, grant=0, rd_en=wr_en=0, rd_off=wr_off=0, done=0, done_id=0, busy=0, and clear the anti-starvation flag.
REQ-034 Reset mid-transfer SHALL abandon the transfer with no done pulse; outputs are zero from the cycle after the reset edge.

Verification
REQ-035 Single lbuf, len=4 -> grant=010; rd_off 0..3 on cycles 1..4; wr_off 0..3 on cycles 2..5; done, done_id=1 on cycle 5; busy 5 cycles.
REQ-036 sha3_req and sbuf_req (len=2) raised together -> sha3 transfer of 25 words (26 busy cycles); then sbuf granted with done_id=2.
REQ-037 Back-to-back sha3 requests with lbuf pending -> after first sha3 done, lbuf granted before second sha3.
REQ-038 sbuf_len=0 and sbuf_len=31 -> each performs 25 writes, wr_off 0..24.
REQ-039 RST=0 at rd_off=10 of a sha3 transfer -> next cycle all outputs 0, no done; a fresh lbuf request then runs normally from offset 0.
REQ-040 Request dropped mid-XFER and lbuf_len changed during transfer -> transfer completes with the originally latched length.
